// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Optional feature macro used by this block: MEM_ARB_RR_EN (round-robin arbitration).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 128;

  // Index width for n items, never below 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational picker: pending mask in, one-hot grant and binary index out.
// MEM_ARB_RR_EN defined: rotating priority from ptr; undefined: lowest index wins, no pointer port.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] pend,
`ifdef MEM_ARB_RR_EN
  input  logic [IW-1:0]      ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

`ifdef MEM_ARB_RR_EN
  localparam logic [IW:0] NUM_W = (IW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IW:0]        sum;

  // Rotate so the pointer slot sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot = NUM_REQ'({pend, pend} >> ptr);
    sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr} + (IW+1)'(k);
    end
    if (sum >= NUM_W) sum = sum - NUM_W;
    idx = sum[IW-1:0];
    gnt = (|rot) ? (NUM_REQ'(1) << idx) : '0;
  end
`else
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend[k]) idx = IW'(k);
    end
    gnt = (|pend) ? (NUM_REQ'(1) << idx) : '0;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request port among NUM_REQ cache controllers via per-port pending slots.
// Arbitration is fixed priority unless MEM_ARB_RR_EN is defined (round-robin).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           req_rdata,
  output logic                        mem_valid,
  output logic                        mem_rw,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err_overrun
);

  localparam int IW = clog2(NUM_REQ);

  arb_state_t state, state_nxt;

  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] rel;

  logic              slot_rw   [NUM_REQ];
  logic [ADDR_W-1:0] slot_addr [NUM_REQ];
  logic [DATA_W-1:0] slot_wdata[NUM_REQ];

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  mem_arb_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .pend (pend),
    .ptr  (rr_ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_ptr <= '0;
    else if (state == RESP)  rr_ptr <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
  end
`else
  mem_arb_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .pend (pend),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );
`endif

  assign rel       = (state == RESP) ? gnt_oh : '0;
  assign req_ready = rel;
  assign mem_valid = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A slot being released this cycle may be refilled in the same edge; that is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_rw[i]    <= 1'b0;
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (!pend[i] || rel[i])) begin
          pend[i]       <= 1'b1;
          slot_rw[i]    <= req_rw[i];
          slot_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          slot_wdata[i] <= req_wdata[i*DATA_W +: DATA_W];
        end else if (rel[i]) begin
          pend[i] <= 1'b0;
        end
        if (req_valid[i] && pend[i] && !rel[i]) err_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id  <= '0;
      gnt_oh    <= '0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_rdata <= '0;
    end else begin
      if (state == IDLE && |pend) begin
        grant_id  <= pick_idx;
        gnt_oh    <= pick_gnt;
        mem_rw    <= slot_rw[pick_idx];
        mem_addr  <= slot_addr[pick_idx];
        mem_wdata <= slot_wdata[pick_idx];
      end
      if (state == WAIT && mem_ready) req_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NUM_REQ=2); expectations follow MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_rw, req_ready;
  logic [63:0]  req_addr;
  logic [255:0] req_wdata;
  logic [127:0] req_rdata, mem_wdata, mem_rdata;
  logic         mem_valid, mem_rw, mem_ready, busy, err_overrun;
  logic [31:0]  mem_addr;
  logic [0:0]   grant_id;

  int n_chk = 0;
  int n_pass = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .err_overrun(err_overrun)
  );

  typedef struct {
    int           port;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           delay;
    int           exp_lat;
    logic [1:0]   exp_ready;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_req(input int p, input logic rw, input logic [31:0] a, input logic [127:0] wd);
    req_valid[p]          = 1'b1;
    req_rw[p]             = rw;
    req_addr[p*32 +: 32]  = a;
    req_wdata[p*128 +: 128] = wd;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  task automatic wait_mem_valid(input string nm, output int cyc);
    cyc = 0;
    while (mem_valid !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk({nm, "_mem_valid_seen"}, mem_valid, 1'b1);
  endtask

  function automatic int first_of_pair();
`ifdef MEM_ARB_RR_EN
    return exp_ptr;
`else
    return 0;
`endif
  endfunction

  // Serve one already-pending grant with mem_ready in the first WAIT cycle.
  task automatic run_grant(input string nm, input int p, input logic [31:0] a, input logic [127:0] rd);
    int cyc;
    logic [1:0] oh;
    oh = 2'b01 << p;
    wait_mem_valid(nm, cyc);
    chk({nm, "_grant_id"}, grant_id, p[0]);
    chk({nm, "_mem_addr"}, mem_addr, a);
    tick();
    mem_ready = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk({nm, "_req_ready"}, req_ready, oh);
    chk({nm, "_req_rdata"}, req_rdata, rd);
    tick();
    exp_ptr = (p + 1) % 2;
  endtask

  vec_t tv[4];

  initial begin
    int cyc;
    rst_n = 1'b0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    tv[0] = '{0, 1'b0, 32'h0000_1230, 128'h0, {16{8'hA5}}, 3, 2, 2'b01};
    tv[1] = '{1, 1'b1, 32'h0003_C000, {4{32'hDEAD_BEEF}}, {8{16'h1111}}, 10, 2, 2'b10};
    tv[2] = '{1, 1'b0, 32'hFFFF_FFF0, 128'h0, {16{8'h5A}}, 1, 2, 2'b10};
    tv[3] = '{0, 1'b1, 32'h0000_0000, {128{1'b1}}, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 2, 2, 2'b01};

    // Reset state
    #1;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_err_overrun", err_overrun, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_req_rdata", req_rdata, 128'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single transactions (T1, T3 and variants)
    for (int v = 0; v < 4; v++) begin
      set_req(tv[v].port, tv[v].rw, tv[v].addr, tv[v].wdata);
      tick();
      clr_req();
      wait_mem_valid("vec", cyc);
      chk("vec_latency", cyc + 1, tv[v].exp_lat);
      chk("vec_mem_addr", mem_addr, tv[v].addr);
      chk("vec_mem_rw", mem_rw, tv[v].rw);
      chk("vec_mem_wdata", mem_wdata, tv[v].wdata);
      chk("vec_grant_id", grant_id, tv[v].port[0]);
      for (int d = 0; d < tv[v].delay; d++) begin
        tick();
        if (d == tv[v].delay - 1) begin
          chk("vec_hold_addr", mem_addr, tv[v].addr);
          chk("vec_hold_wdata", mem_wdata, tv[v].wdata);
          chk("vec_hold_rw", mem_rw, tv[v].rw);
          chk("vec_wait_no_valid", mem_valid, 1'b0);
          chk("vec_wait_no_ready", req_ready, 2'b00);
        end
      end
      mem_ready = 1'b1;
      mem_rdata = tv[v].rdata;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk("vec_req_ready", req_ready, tv[v].exp_ready);
      chk("vec_req_rdata", req_rdata, tv[v].rdata);
      tick();
      chk("vec_ready_drop", req_ready, 2'b00);
      chk("vec_rdata_hold", req_rdata, tv[v].rdata);
      chk("vec_idle", busy, 1'b0);
      exp_ptr = (tv[v].port + 1) % 2;
    end

    // T2: simultaneous pairs; pointer history decides the order under round-robin
    begin
      int f;
      logic [31:0] pa[2];
      pa[0] = 32'h0000_0100;
      pa[1] = 32'h0000_0200;
      set_req(1, 1'b0, 32'h0000_0300, 128'h0);
      tick(); clr_req();
      run_grant("t2_pre1", 1, 32'h0000_0300, 128'h33);
      set_req(0, 1'b0, pa[0], 128'h0);
      set_req(1, 1'b0, pa[1], 128'h0);
      tick(); clr_req();
      f = first_of_pair();
      run_grant("t2_pair1_first", f, pa[f], 128'h41);
      run_grant("t2_pair1_second", 1 - f, pa[1 - f], 128'h42);
      set_req(0, 1'b0, 32'h0000_0400, 128'h0);
      tick(); clr_req();
      run_grant("t2_pre0", 0, 32'h0000_0400, 128'h44);
      set_req(0, 1'b0, pa[0], 128'h0);
      set_req(1, 1'b0, pa[1], 128'h0);
      tick(); clr_req();
      f = first_of_pair();
      run_grant("t2_pair2_first", f, pa[f], 128'h51);
      run_grant("t2_pair2_second", 1 - f, pa[1 - f], 128'h52);
    end

    // New valid in the release cycle is captured, not an overrun
    set_req(0, 1'b0, 32'h0000_6660, 128'h0);
    tick(); clr_req();
    wait_mem_valid("rel", cyc);
    tick();
    mem_ready = 1'b1; mem_rdata = 128'h66;
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    chk("rel_req_ready", req_ready, 2'b01);
    set_req(0, 1'b0, 32'h0000_7770, 128'h0);
    tick(); clr_req();
    chk("rel_busy_idle", busy, 1'b0);
    exp_ptr = 1;
    run_grant("rel_recapture", 0, 32'h0000_7770, 128'h77);
    chk("rel_no_overrun", err_overrun, 1'b0);

    // T4: overrun drops the second request and is sticky
    set_req(0, 1'b0, 32'h0000_4000, 128'h0);
    tick();
    set_req(0, 1'b1, 32'h0000_9999, {4{32'hBAD0_BAD0}});
    tick(); clr_req();
    chk("t4_overrun", err_overrun, 1'b1);
    chk("t4_mem_rw", mem_rw, 1'b0);
    run_grant("t4_orig", 0, 32'h0000_4000, 128'h4);
    repeat (3) tick();
    chk("t4_no_second", busy, 1'b0);
    chk("t4_sticky", err_overrun, 1'b1);

    // T5: mem_ready during ISSUE is ignored
    set_req(1, 1'b0, 32'h0000_5000, 128'h0);
    tick(); clr_req();
    wait_mem_valid("t5", cyc);
    mem_ready = 1'b1; mem_rdata = 128'hBAD;
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    chk("t5_still_busy", busy, 1'b1);
    chk("t5_no_ready", req_ready, 2'b00);
    tick(); tick();
    chk("t5_still_wait", req_ready, 2'b00);
    chk("t5_no_reissue", mem_valid, 1'b0);
    mem_ready = 1'b1; mem_rdata = 128'h55;
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    chk("t5_req_ready", req_ready, 2'b10);
    chk("t5_req_rdata", req_rdata, 128'h55);
    tick();
    exp_ptr = 0;

    // T6: reset during WAIT abandons the transfer
    set_req(0, 1'b0, 32'h0000_6000, 128'h0);
    tick(); clr_req();
    wait_mem_valid("t6", cyc);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_req_rdata", req_rdata, 128'h0);
    chk("t6_overrun_clr", err_overrun, 1'b0);
    mem_ready = 1'b1; mem_rdata = 128'hEE;
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    chk("t6_no_req_ready", req_ready, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle_after", busy, 1'b0);
    exp_ptr = 0;
    set_req(1, 1'b1, 32'h0000_5550, {4{32'hCAFE_F00D}});
    tick(); clr_req();
    run_grant("t6_after_reset", 1, 32'h0000_5550, 128'h56);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
